// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event classifier.
// Holds the FSM state encoding, event codes and counter widths.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    localparam logic [1:0] EV_NONE     = 2'b00;
    localparam logic [1:0] EV_SHORT    = 2'b01;
    localparam logic [1:0] EV_LONG     = 2'b10;
    localparam logic [1:0] EV_LONG_REL = 2'b11;

    localparam int HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = 8'hFF;

    // Tick counter width; never narrower than one bit.
    function automatic int tick_w(input int tt);
        return (tt > 1) ? $clog2(tt) : 1;
    endfunction

endpackage

// File: rtl/key_event_tick_gen.sv
// Hold-tick prescaler: counts 0..TIME_TICK-1 and pulses tick on the last count.
// clr holds the counter at zero.
module tick_gen
    import key_event_pkg::*;
#(
    parameter int TIME_TICK = 1000000
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    output logic tick
);

    localparam int TW = tick_w(TIME_TICK);
    localparam logic [TW-1:0] LAST = TW'(TIME_TICK - 1);

    logic [TW-1:0] cnt_r;

    // Prescaler counter with wrap at LAST.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_r <= {TW{1'b0}};
        end else if (clr) begin
            cnt_r <= {TW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {TW{1'b0}};
        end else begin
            cnt_r <= cnt_r + TW'(1);
        end
    end

    assign tick = ~clr & (cnt_r == LAST);

endmodule

// File: rtl/key_event.sv
// Classifies debounced key presses into SHORT / LONG / LONG_RELEASE events
// and holds the last event until the consumer acknowledges it.
module key_event
    import key_event_pkg::*;
#(
    parameter int TIME_TICK = 1000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ena,
    input  logic       data_in,
    input  logic [7:0] long_time,
    input  logic       event_ack,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       overflow
);

    state_t            state_r, state_s;
    logic              data_d_r, armed_r;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W:0]   hold_inc_s;
    logic              tick_s, tick_clr_s, hold_clr_s;
    logic              rise_s, fall_s, long_hit_s;
    logic              emit_s, press_s, release_s, ack_s;
    logic [1:0]        emit_code_s;
    logic              press_pulse_r, release_pulse_r, event_valid_r, overflow_r;
    logic [1:0]        event_code_r;

    // armed_r masks the first cycle after reset so a key held through reset is not a rise.
    assign rise_s     = data_in & ~data_d_r & armed_r;
    assign fall_s     = ~data_in & data_d_r;
    assign tick_clr_s = ~ena | (state_r != ST_PRESSED);
    assign hold_clr_s = ~ena | (state_r == ST_IDLE);
    assign hold_inc_s = {1'b0, hold_r} + 9'd1;
    assign ack_s      = event_ack & event_valid_r;

    // Threshold hit either on the wrap that reaches long_time or when already equal.
    assign long_hit_s = (long_time != 8'd0) &&
                        ((hold_r == long_time) ||
                         (tick_s && (hold_inc_s == {1'b0, long_time})));

    tick_gen #(.TIME_TICK(TIME_TICK)) u_tick_gen (
        .clk  (clk),
        .res  (res),
        .clr  (tick_clr_s),
        .tick (tick_s)
    );

    // Edge-detect history of the key level.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_d_r <= 1'b0;
            armed_r  <= 1'b0;
        end else begin
            data_d_r <= data_in;
            armed_r  <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and event emission.
    always_comb begin
        state_s     = state_r;
        emit_s      = 1'b0;
        emit_code_s = EV_NONE;
        press_s     = 1'b0;
        release_s   = 1'b0;
        if (!ena) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_s = ST_PRESSED;
                        press_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (fall_s) begin
                        state_s     = ST_IDLE;
                        release_s   = 1'b1;
                        emit_s      = 1'b1;
                        emit_code_s = EV_SHORT;
                    end else if (long_hit_s) begin
                        state_s     = ST_LONG_HELD;
                        emit_s      = 1'b1;
                        emit_code_s = EV_LONG;
                    end else begin
                        state_s = ST_PRESSED;
                    end
                end
                ST_LONG_HELD: begin
                    if (fall_s) begin
                        state_s     = ST_IDLE;
                        release_s   = 1'b1;
                        emit_s      = 1'b1;
                        emit_code_s = EV_LONG_REL;
                    end else begin
                        state_s = ST_LONG_HELD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Hold counter: counts ticks while pressed, saturates, frozen in LONG_HELD.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (hold_clr_s) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if ((state_r == ST_PRESSED) && tick_s && (hold_r != HOLD_MAX)) begin
            hold_r <= hold_r + 8'd1;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Registered press/release pulses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            press_pulse_r   <= press_s;
            release_pulse_r <= release_s;
        end
    end

    // Single-entry event register with sticky drop flag.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            event_valid_r <= 1'b0;
            event_code_r  <= EV_NONE;
            overflow_r    <= 1'b0;
        end else if (emit_s && (!event_valid_r || event_ack)) begin
            event_valid_r <= 1'b1;
            event_code_r  <= emit_code_s;
            overflow_r    <= ack_s ? 1'b0 : overflow_r;
        end else if (emit_s) begin
            overflow_r <= 1'b1;
        end else if (ack_s) begin
            event_valid_r <= 1'b0;
            event_code_r  <= EV_NONE;
            overflow_r    <= 1'b0;
        end else begin
            event_valid_r <= event_valid_r;
        end
    end

    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign event_valid   = event_valid_r;
    assign event_code    = event_code_r;
    assign overflow      = overflow_r;

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter TIME_TICK, default 1000000, clk cycles per hold tick (10 ms at 100 MHz).
REQ-002 clk  input  1  system clock, 100 MHz expected.
REQ-003 res  input  1  asynchronous active-high reset.
REQ-004 ena  input  1  enable; 0 = block idle, no events.
REQ-005 data_in  input  1  debounced key level from debouncer data_out; 1 = pressed.
REQ-006 long_time  input  8  long-press threshold in hold ticks; 0 = long detection disabled.
REQ-007 event_ack  input  1  consumer acknowledge of held event.
REQ-008 press_pulse  output  1  one-cycle pulse on press.
REQ-009 release_pulse  output  1  one-cycle pulse on release.
REQ-010 event_valid  output  1  event register holds an unacknowledged event.
REQ-011 event_code  output  2  01 SHORT, 10 LONG, 11 LONG_RELEASE, 00 none.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 All outputs SHALL be registered; data_in is already synchronous and SHALL NOT be resynchronised.
REQ-014 data_d SHALL register data_in every cycle regardless of ena; rise = data_in & ~data_d, fall = ~data_in & data_d.
REQ-015 FSM states: IDLE, PRESSED, LONG_HELD.
REQ-016 IDLE: rise with ena=1 -> PRESSED, clear tick and hold counters, press_pulse=1 next cycle.
REQ-017 PRESSED: tick counter counts 0..TIME_TICK-1 and wraps; on each wrap the hold counter increments, saturating at 255.
REQ-018 PRESSED: when long_time!=0 and hold counter equals long_time -> LONG_HELD and emit LONG; the LONG event is therefore emitted long_time*TIME_TICK cycles after entry to PRESSED.
REQ-019 PRESSED: fall -> IDLE, release_pulse=1, emit SHORT.
REQ-020 LONG_HELD: counters frozen; fall -> IDLE, release_pulse=1, emit LONG_RELEASE.
REQ-021 A fall seen in IDLE (key already held when enabled) SHALL be ignored: no pulse, no event.
REQ-022 Emit: if event_valid=0, or event_ack=1 in the same cycle, load event_code and set event_valid=1 the next cycle.
REQ-023 Emit while event_valid=1 and event_ack=0: the new event is dropped, the held code is unchanged, and overflow is set.
REQ-024 event_ack with no simultaneous emit SHALL clear event_valid, set event_code=00, and clear overflow the next cycle.
REQ-025 event_ack while event_valid=0 SHALL have no effect.
REQ-026 ena=0 SHALL force the FSM to IDLE, clear the counters, and suppress pulses and emits; the event register, event_valid and overflow SHALL still be cleared by event_ack.
REQ-027 long_time changes mid-press SHALL take effect at the next comparison; if long_time is already below the hold counter, no LONG is emitted for that press.

Reset
REQ-028 res=1 SHALL asynchronously force: state IDLE, data_d=0, counters=0, press_pulse=0, release_pulse=0, event_valid=0, event_code=00, overflow=0.
REQ-029 Reset mid-press SHALL discard the press; after release of reset, a still-high data_in SHALL NOT produce press_pulse until a new rise.

Structure
REQ-030 key_event_pkg SHALL hold the FSM state enum, the event code constants (EV_NONE, EV_SHORT, EV_LONG, EV_LONG_REL), and the counter widths.
REQ-031 The tick prescaler SHALL be a sub-module tick_gen (parameter TIME_TICK; inputs clk, res, clr; output tick pulse).
REQ-032 Tick counter width SHALL be $clog2(TIME_TICK); hold counter width 8.

Verification (TIME_TICK overridden to 10)
REQ-033 Press for 30 cycles with long_time=5, then release -> one press_pulse, one release_pulse, event_code=01, event_valid=1.
REQ-034 Hold for 60 cycles with long_time=5 -> event_code=10 exactly 50 cycles after press entry; ack; release -> event_code=11.
REQ-035 Two SHORT presses with no ack -> event_code=01 retained, overflow=1; ack -> event_valid=0, overflow=0.
REQ-036 Release emitting an event in the same cycle as event_ack of a pending event -> new code loaded, event_valid stays 1, overflow stays 0.
REQ-037 Set ena=1 while data_in=1, then release -> no pulses, no event; long_time=0 with a 200-cycle hold -> SHORT only.
REQ-038 Assert res in LONG_HELD with data_in high, then deassert -> all outputs 0 and no press_pulse until data_in falls and rises again.
